// File: rtl/mac_tx_sched_if.sv
// mac_tx_sched_if: request/grant bundle and mac_tx handshake for mac_tx_sched.
// The master side belongs to the frame sources and mac_tx; the slave side belongs to the scheduler.
interface mac_tx_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 9
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     mac_start;
    logic [31:0]              mac_payload_len;
    logic [SEL_W-1:0]         mac_sel;
    logic                     mac_tx_valid;
    logic                     mac_tx_last;
    logic                     busy;
    logic                     len_err;
    logic                     timeout;

    modport master (
        output req, req_len, mac_tx_valid, mac_tx_last,
        input  gnt, done, mac_start, mac_payload_len, mac_sel, busy, len_err, timeout
    );

    modport slave (
        input  req, req_len, mac_tx_valid, mac_tx_last,
        output gnt, done, mac_start, mac_payload_len, mac_sel, busy, len_err, timeout
    );
endinterface

// File: rtl/mac_tx_sched.sv
// mac_tx_sched: round-robin scheduler sharing one mac_tx engine between NUM_REQ frame sources.
// Optional macro MAC_TX_SCHED_STRICT_PRIO_EN gives source 0 strict priority over the round-robin.
module mac_tx_sched #(
    parameter int NUM_REQ        = 4,
    parameter int LEN_W          = 9,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    mac_tx_sched_if.slave bus
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
    localparam logic [31:0]      MAX_LEN  = 32'd256;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] START  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               start_q, start_d;
    logic [31:0]        len_q, len_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               len_err_q, len_err_d;
    logic               timeout_q, timeout_d;

    logic [LEN_W-1:0]   len_arr [NUM_REQ];
    logic               pick_vld;
    logic [SEL_W-1:0]   pick;
    logic [31:0]        pick_len;
    logic [SEL_W-1:0]   ptr_next;
    logic               end_frame;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            len_arr[i] = bus.req_len[i*LEN_W +: LEN_W];
        end
    end

    // Cyclic search starting at the RR pointer; first hit wins.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_vld && bus.req[SEL_W'(idx)]) begin
                pick_vld = 1'b1;
                pick     = SEL_W'(idx);
            end
        end
`ifdef MAC_TX_SCHED_STRICT_PRIO_EN
        if (bus.req[0]) begin
            pick_vld = 1'b1;
            pick     = '0;
        end
`endif
    end

    assign pick_len = 32'(len_arr[pick]);
    assign ptr_next = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        len_d     = len_q;
        done_d    = '0;
        start_d   = 1'b0;
        len_err_d = 1'b0;
        timeout_d = 1'b0;
        end_frame = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d     = START;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    sel_d       = pick;
                    len_d       = (pick_len > MAX_LEN) ? MAX_LEN : pick_len;
                    len_err_d   = (pick_len > MAX_LEN);
                end
            end
            START: begin
                state_d = ACTIVE;
                start_d = 1'b1;
                wd_d    = '0;
            end
            ACTIVE: begin
                if (bus.mac_tx_valid && bus.mac_tx_last) begin
                    done_d    = gnt_q;
                    end_frame = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    end_frame = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (end_frame) begin
            gnt_d   = '0;
            gap_d   = '0;
            state_d = (IFG_CYCLES == 0) ? IDLE : GAP;
`ifdef MAC_TX_SCHED_STRICT_PRIO_EN
            if (sel_q != '0) ptr_d = ptr_next;
`else
            ptr_d = ptr_next;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wd_q      <= '0;
            gap_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            len_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            gap_q     <= gap_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            start_q   <= start_d;
            len_q     <= len_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            len_err_q <= len_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.done            = done_q;
    assign bus.mac_start       = start_q;
    assign bus.mac_payload_len = len_q;
    assign bus.mac_sel         = sel_q;
    assign bus.busy            = busy_q;
    assign bus.len_err         = len_err_q;
    assign bus.timeout         = timeout_q;
endmodule

// File: tb/tb_mac_tx_sched.sv
// tb_mac_tx_sched: randomized bench for mac_tx_sched with a transaction-level scheduler model
// and a simple mac_tx byte model (length + 1 valid bytes per frame, last on the final one).
module tb_mac_tx_sched;
    localparam int N   = 4;
    localparam int LW  = 9;
    localparam int IFG = 12;
    localparam int TO  = 1024;
`ifdef MAC_TX_SCHED_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_tx_sched_if #(.NUM_REQ(N), .LEN_W(LW)) bus ();

    mac_tx_sched #(
        .NUM_REQ(N), .LEN_W(LW), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Requester stimulus
    logic [N-1:0] rq;
    int unsigned  rlen [N];
    bit           locked [N];
    bit           in_reset, rand_req, hang, chk_gap;
    int unsigned  vld_pct;

    // Scheduler model: frame currently granted, pending grant, end-of-frame event
    bit m_active, g_pend, end_done;
    int m_ptr, m_idx, m_len, m_raw, m_gcyc, m_ready, bytes_left;
    int g_cyc, g_idx, g_raw, end_cyc, ended;
    bit ev_end, ev_to, ev_gnt;

    int           lastT;
    logic [N-1:0] gnt_prev;
    int           gseq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int arb(input logic [N-1:0] r, input int ptr);
        if (STRICT && r[0]) return 0;
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic int unsigned rand_len();
        case ($urandom_range(3))
            0:       return $urandom_range(3);
            1, 2:    return $urandom_range(40);
            default: return 250 + $urandom_range(20);
        endcase
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_active   = 1'b0;
        g_pend     = 1'b0;
        end_done   = 1'b0;
        m_ptr      = 0;
        m_ready    = 0;
        bytes_left = 0;
        end_cyc    = 0;
        lastT      = -1;
        gnt_prev   = '0;
        for (int i = 0; i < N; i++) locked[i] = 1'b0;
    endtask

    // One clock: drive inputs, advance, resolve model events, compare every output.
    task automatic tick();
        bit drv_v, drv_l;
        logic [N*LW-1:0] lenbus;
        logic [31:0] exp_gnt, exp_done;
        drv_v  = 1'b0;
        drv_l  = 1'b0;
        ev_end = 1'b0;
        ev_to  = 1'b0;
        ev_gnt = 1'b0;
        if (!in_reset) begin
            if (m_active && cyc >= m_gcyc + 1) begin
                if (hang) begin
                    drv_v = 1'($urandom_range(1));
                end else if (bytes_left > 0 && $urandom_range(99) < vld_pct) begin
                    drv_v = 1'b1;
                    bytes_left--;
                    if (bytes_left == 0) begin
                        drv_l    = 1'b1;
                        end_cyc  = cyc + 1;
                        end_done = 1'b1;
                        lastT    = cyc;
                    end
                end
            end else if ($urandom_range(7) == 0) begin
                drv_v = 1'b1;
                drv_l = 1'b1;
            end
            if (rand_req) begin
                for (int i = 0; i < N; i++) begin
                    if (m_active && i == m_idx) begin
                        if (rq[i] && $urandom_range(15) == 0) begin
                            rq[i]     = 1'b0;
                            locked[i] = 1'b1;
                        end
                        if ($urandom_range(7) == 0) rlen[i] = rand_len();
                    end else if (!rq[i] && !locked[i] && $urandom_range(3) == 0) begin
                        rq[i]   = 1'b1;
                        rlen[i] = rand_len();
                    end
                end
            end
            if (!m_active && !g_pend && cyc >= m_ready && rq != '0) begin
                g_pend = 1'b1;
                g_cyc  = cyc + 1;
                g_idx  = arb(rq, m_ptr);
                g_raw  = int'(rlen[g_idx]);
            end
        end
        for (int i = 0; i < N; i++) lenbus[i*LW +: LW] = LW'(rlen[i]);
        bus.req          = rq;
        bus.req_len      = lenbus;
        bus.mac_tx_valid = drv_v;
        bus.mac_tx_last  = drv_l;

        @(posedge clk);
        #1;
        cyc++;

        if (!in_reset) begin
            if (m_active && cyc == end_cyc) begin
                ev_end     = 1'b1;
                ev_to      = !end_done;
                ended      = m_idx;
                m_active   = 1'b0;
                bytes_left = 0;
                if (!(STRICT && m_idx == 0)) m_ptr = (m_idx + 1) % N;
                m_ready = cyc + IFG;
                if (rand_req) begin
                    rq[m_idx]     = 1'b0;
                    locked[m_idx] = 1'b0;
                end
            end
            if (g_pend && cyc == g_cyc) begin
                g_pend     = 1'b0;
                ev_gnt     = 1'b1;
                m_active   = 1'b1;
                m_idx      = g_idx;
                m_raw      = g_raw;
                m_len      = (g_raw > 256) ? 256 : g_raw;
                m_gcyc     = cyc;
                end_cyc    = cyc + TO + 1;
                end_done   = 1'b0;
                bytes_left = m_len + 1;
            end
        end

        exp_gnt  = m_active ? (32'd1 << m_idx) : 32'd0;
        exp_done = (ev_end && !ev_to) ? (32'd1 << ended) : 32'd0;
        check("gnt",       32'(bus.gnt),       exp_gnt);
        check("done",      32'(bus.done),      exp_done);
        check("timeout",   32'(bus.timeout),   32'(ev_to));
        check("mac_start", 32'(bus.mac_start), 32'(m_active && cyc == m_gcyc + 1));
        check("len_err",   32'(bus.len_err),   32'(ev_gnt && m_raw > 256));
        check("busy",      32'(bus.busy),      32'(!in_reset && (m_active || cyc < m_ready)));
        if (m_active) begin
            check("mac_sel", 32'(bus.mac_sel),    32'(m_idx));
            check("mac_len", bus.mac_payload_len, 32'(m_len));
        end else if (in_reset) begin
            check("rst_sel", 32'(bus.mac_sel),    32'd0);
            check("rst_len", bus.mac_payload_len, 32'd0);
        end

        if (gnt_prev == '0 && bus.gnt != '0) begin
            gseq.push_back(oh_idx(bus.gnt));
            if (chk_gap && lastT >= 0) check("ifg_gap", 32'(cyc - lastT), 32'(IFG + 2));
        end
        gnt_prev = bus.gnt;
    endtask

    task automatic wait_end(input int max_cyc, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            tick();
            seen = ev_end;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_gnt(input int max_cyc, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            tick();
            seen = ev_gnt;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_reset = 1'b1;
        model_reset();
        repeat (2) tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        rq       = '0;
        rand_req = 1'b0;
        hang     = 1'b0;
        chk_gap  = 1'b0;
        vld_pct  = 100;
        in_reset = 1'b1;
        ended    = 0;
        model_reset();

        // Reset with all four requesting, then round-robin 0,1,2,3,0 with IFG spacing
        rq = '1;
        for (int i = 0; i < N; i++) rlen[i] = 4;
        repeat (3) tick();
        release_reset();
        chk_gap = 1'b1;
        repeat (5) wait_end(200, "rr_wait");
        chk_gap = 1'b0;
        check("rr_cnt", 32'(gseq.size()), 32'd5);
        if (gseq.size() >= 5) begin
            check("rr_0", 32'(gseq[0]), 32'd0);
            check("rr_1", 32'(gseq[1]), 32'd1);
            check("rr_2", 32'(gseq[2]), 32'd2);
            check("rr_3", 32'(gseq[3]), 32'd3);
            check("rr_4", 32'(gseq[4]), 32'd0);
        end

        // Oversized length clamps; req drop and length change after grant are ignored
        rq      = 4'b0100;
        rlen[2] = 300;
        wait_gnt(100, "clamp_gnt");
        rlen[2] = 7;
        rq      = '0;
        wait_end(600, "clamp_wait");

        // mac_tx never finishes: watchdog abort
        rq   = 4'b1000;
        hang = 1'b1;
        wait_end(TO + 60, "wd_wait");
        check("wd_flag", 32'(ev_to), 32'd1);
        rq   = '0;
        hang = 1'b0;
        repeat (IFG + 4) tick();

        // Reset in the middle of an active frame, then a fresh grant to source 2
        rq      = 4'b0010;
        rlen[1] = 20;
        wait_gnt(60, "mid_gnt");
        repeat (5) tick();
        #2;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        #1;
        check("mid_gnt0",   32'(bus.gnt),       32'd0);
        check("mid_busy0",  32'(bus.busy),      32'd0);
        check("mid_start0", 32'(bus.mac_start), 32'd0);
        model_reset();
        repeat (3) tick();
        rq      = 4'b0100;
        rlen[2] = 9;
        gseq.delete();
        release_reset();
        wait_end(100, "post_rst_wait");
        check("post_rst_src", 32'(gseq.size() > 0 ? gseq[0] : -1), 32'd2);

        // Source 0 raised during the first frame of a 1110 pattern
        rq = '0;
        do_reset();
        rq = 4'b1110;
        for (int i = 0; i < N; i++) rlen[i] = 4;
        gseq.delete();
        release_reset();
        wait_gnt(20, "prio_gnt");
        repeat (3) tick();
        rq[0] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_end(200, "prio_wait");
            if (ended == 0) rq[0] = 1'b0;
        end
        repeat (IFG + 3) tick();
        if (gseq.size() >= 3) begin
            check("prio_0", 32'(gseq[0]), 32'd1);
            check("prio_1", 32'(gseq[1]), STRICT ? 32'd0 : 32'd2);
            check("prio_2", 32'(gseq[2]), STRICT ? 32'd2 : 32'd3);
        end else begin
            check("prio_cnt", 32'(gseq.size()), 32'd3);
        end

        // Randomized traffic with spurious last, req drops and late length changes
        rq = '0;
        do_reset();
        release_reset();
        rand_req = 1'b1;
        vld_pct  = 75;
        repeat (4000) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1);
    end
endmodule
